// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC error monitor: error type codes, capture
// FSM states and the type-priority encoder.
package ecc_pkg;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_SBIT  = 2'b01;
    localparam logic [1:0] ERR_DBIT  = 2'b10;
    localparam logic [1:0] ERR_FAULT = 2'b11;

    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_HELD = 1'b1
    } cap_state_t;

    // Highest-severity flag wins: fault > dbit > sbit.
    function automatic logic [1:0] err_type(input logic fault, input logic dbit,
                                            input logic sbit);
        if (fault)     return ERR_FAULT;
        else if (dbit) return ERR_DBIT;
        else if (sbit) return ERR_SBIT;
        else           return ERR_NONE;
    endfunction

endpackage

// File: rtl/ecc_sat_cnt.sv
// Saturating event counter; a clear coinciding with an increment leaves
// the count at 1 so the event is not lost.
module ecc_sat_cnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt
);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of process ordering in simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= {{(CNT_WIDTH-1){1'b0}}, inc};
        end else if (inc && (cnt != {CNT_WIDTH{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ecc_137_err_mon.sv
// Read-path ECC monitor: registers the corrected word, counts events, holds
// sticky flags and a first-error capture, and drives a level interrupt.
module ecc_137_err_mon
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH  = 137,
    parameter int ADDR_WIDTH  = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int SBIT_THRESH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_vld,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  sbit_err,
    input  logic                  dbit_err,
    input  logic                  ecc_fault,
    input  logic                  err_clr,
    input  logic                  cnt_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_vld,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic [CNT_WIDTH-1:0]  fault_cnt,
    output logic [2:0]            err_sticky,
    output logic                  cap_vld,
    output logic [ADDR_WIDTH-1:0] cap_addr,
    output logic [1:0]            cap_type,
    output logic                  cap_ovf,
    output logic                  err_irq
);

    localparam int unsigned THRESH = SBIT_THRESH;

    logic                  sbit_ev, dbit_ev, fault_ev, any_ev;
    logic [1:0]            ev_type;
    logic [2:0]            sticky_nxt;
    logic [CNT_WIDTH-1:0]  sbit_cnt_nxt;
    logic                  irq_nxt;

    cap_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] cap_addr_nxt;
    logic [1:0]            cap_type_nxt;
    logic                  cap_ovf_nxt;

    assign sbit_ev  = rd_vld & sbit_err;
    assign dbit_ev  = rd_vld & dbit_err;
    assign fault_ev = rd_vld & ecc_fault;
    assign any_ev   = sbit_ev | dbit_ev | fault_ev;
    assign ev_type  = err_type(fault_ev, dbit_ev, sbit_ev);
    assign cap_vld  = (state == CAP_HELD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            data_vld <= 1'b0;
        end else begin
            data_vld <= rd_vld;
            if (rd_vld) data_out <= data_in;
        end
    end

    ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_sbit_cnt (
        .clk(clk), .rst(rst), .inc(sbit_ev), .clr(cnt_clr), .cnt(sbit_cnt)
    );
    ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_dbit_cnt (
        .clk(clk), .rst(rst), .inc(dbit_ev), .clr(cnt_clr), .cnt(dbit_cnt)
    );
    ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_fault_cnt (
        .clk(clk), .rst(rst), .inc(fault_ev), .clr(cnt_clr), .cnt(fault_cnt)
    );

    // The irq register is fed from next-state values so it lines up with
    // the sticky flags and counters it summarises.
    always_comb begin
        sticky_nxt = (err_clr ? 3'b000 : err_sticky) | {fault_ev, dbit_ev, sbit_ev};
        if (cnt_clr)
            sbit_cnt_nxt = {{(CNT_WIDTH-1){1'b0}}, sbit_ev};
        else if (sbit_ev && (sbit_cnt != {CNT_WIDTH{1'b1}}))
            sbit_cnt_nxt = sbit_cnt + 1'b1;
        else
            sbit_cnt_nxt = sbit_cnt;
        irq_nxt = (|sticky_nxt[2:1]) | (32'(sbit_cnt_nxt) >= THRESH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 3'b000;
            err_irq    <= 1'b0;
        end else begin
            err_sticky <= sticky_nxt;
            err_irq    <= irq_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_nxt    = state;
        cap_addr_nxt = cap_addr;
        cap_type_nxt = cap_type;
        cap_ovf_nxt  = cap_ovf;
        unique case (state)
            CAP_IDLE: begin
                if (any_ev) begin
                    state_nxt    = CAP_HELD;
                    cap_addr_nxt = rd_addr;
                    cap_type_nxt = ev_type;
                    cap_ovf_nxt  = 1'b0;
                end
            end
            CAP_HELD: begin
                if (err_clr && any_ev) begin
                    cap_addr_nxt = rd_addr;
                    cap_type_nxt = ev_type;
                    cap_ovf_nxt  = 1'b0;
                end else if (err_clr) begin
                    state_nxt    = CAP_IDLE;
                    cap_addr_nxt = '0;
                    cap_type_nxt = ERR_NONE;
                    cap_ovf_nxt  = 1'b0;
                end else if (any_ev) begin
                    cap_ovf_nxt  = 1'b1;
                end
            end
            default: state_nxt = CAP_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CAP_IDLE;
            cap_addr <= '0;
            cap_type <= ERR_NONE;
            cap_ovf  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cap_addr <= cap_addr_nxt;
            cap_type <= cap_type_nxt;
            cap_ovf  <= cap_ovf_nxt;
        end
    end

endmodule
